// File: rtl/instr_fetch_pkg.sv
// Types and constants shared by the instruction fetch unit and its halfword buffer.
`include "riscv_defines.v"

package instr_fetch_pkg;

    localparam int WORD_W    = `RISCV_WORD_WIDTH;
    localparam int ADDR_W    = `RISCV_ADDR_WIDTH;
    localparam int HW_W      = `RISCV_HWORD_WIDTH;
    localparam int BUF_SLOTS = 3;

    // Request tracking: idle, one live request, or one request whose data
    // belongs to a path abandoned by a redirect.
    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_WAIT = 2'd1,
        FS_DROP = 2'd2
    } fetch_state_e;

    // A halfword starts a 32-bit instruction only when its two LSBs are 11.
    function automatic logic is_compressed(input logic [HW_W-1:0] hw);
        return hw[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/instr_fetch_buffer.sv
// Three-slot halfword queue: pushes 1 or 2 halfwords, pops 1 or 2, flushes.
// Slot 0 always holds the oldest halfword.
`include "riscv_defines.v"

module fetch_buffer
    import instr_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [1:0]        push_cnt,
    input  logic [WORD_W-1:0] push_data,
    input  logic [1:0]        pop_cnt,
    output logic [HW_W-1:0]   slot0,
    output logic [HW_W-1:0]   slot1,
    output logic [1:0]        count
);

    logic [BUF_SLOTS-1:0][HW_W-1:0] slots;
    logic [BUF_SLOTS-1:0][HW_W-1:0] slots_nxt;
    logic [1:0]                     count_nxt;
    logic [1:0]                     base;
    logic [HW_W-1:0]                push_lo;
    logic [HW_W-1:0]                push_hi;

    assign push_lo = push_data[HW_W-1:0];
    assign push_hi = push_data[WORD_W-1:HW_W];

    // Shift out popped halfwords, then append new ones behind the survivors.
    always_comb begin
        slots_nxt = slots;
        count_nxt = count;
        base      = count - pop_cnt;
        if (flush) begin
            count_nxt = 2'd0;
        end else begin
            unique case (pop_cnt)
                2'd0:    slots_nxt = slots;
                2'd1:    slots_nxt = {{HW_W{1'b0}}, slots[2:1]};
                default: slots_nxt = {{(2*HW_W){1'b0}}, slots[2]};
            endcase
            // The request gate guarantees base + push_cnt never exceeds 3.
            unique case (base)
                2'd0: begin
                    if (push_cnt != 2'd0) slots_nxt[0] = push_lo;
                    if (push_cnt == 2'd2) slots_nxt[1] = push_hi;
                end
                2'd1: begin
                    if (push_cnt != 2'd0) slots_nxt[1] = push_lo;
                    if (push_cnt == 2'd2) slots_nxt[2] = push_hi;
                end
                2'd2: begin
                    if (push_cnt != 2'd0) slots_nxt[2] = push_lo;
                end
                default: ;
            endcase
            count_nxt = base + push_cnt;
        end
    end

    // Buffer storage and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slots <= '0;
            count <= 2'd0;
        end else begin
            slots <= slots_nxt;
            count <= count_nxt;
        end
    end

    assign slot0 = slots[0];
    assign slot1 = slots[1];

endmodule

// File: rtl/riscv_defines.v
// Shared RISC-V datapath widths.
`ifndef RISCV_DEFINES_V
`define RISCV_DEFINES_V

`define RISCV_WORD_WIDTH  32
`define RISCV_ADDR_WIDTH  32
`define RISCV_HWORD_WIDTH 16

`endif

// File: rtl/instr_fetch.sv
// Instruction fetch: one-outstanding word requests into a halfword buffer,
// RVC-aware instruction extraction, and redirect (jump) handling.
`include "riscv_defines.v"

module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [`RISCV_ADDR_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    output logic                         mem_req_o,
    output logic [`RISCV_ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                         mem_rvalid_i,
    input  logic [`RISCV_WORD_WIDTH-1:0] mem_rdata_i,
    input  logic                         jump_i,
    input  logic [`RISCV_ADDR_WIDTH-1:0] jump_addr_i,
    output logic [`RISCV_WORD_WIDTH-1:0] instr_o,
    output logic [`RISCV_ADDR_WIDTH-1:0] instr_addr_o,
    output logic                         instr_valid_o,
    input  logic                         instr_ready_i
);

    fetch_state_e      state;
    logic [ADDR_W-1:0] fetch_ptr;
    logic [ADDR_W-1:0] instr_addr;
    logic              misalign;

    logic [HW_W-1:0]   slot0;
    logic [HW_W-1:0]   slot1;
    logic [1:0]        count;
    logic              rvc;
    logic              fire;
    logic              accept;
    logic [1:0]        pop_cnt;
    logic [1:0]        push_cnt;
    logic [WORD_W-1:0] push_data;

    // Decode the head of the buffer and derive handshakes with memory and decoder.
    always_comb begin
        rvc           = is_compressed(slot0);
        instr_valid_o = !jump_i && ((count >= 2'd2) || (count == 2'd1 && rvc));
        instr_o       = rvc ? {{HW_W{1'b0}}, slot0} : {slot1, slot0};
        fire          = instr_valid_o && instr_ready_i;
        pop_cnt       = fire ? (rvc ? 2'd1 : 2'd2) : 2'd0;
        // Refill only when at least two slots are free, so a full word always fits.
        mem_req_o     = rst_n && (state == FS_IDLE) && (count <= 2'd1) && !jump_i;
        accept        = mem_rvalid_i && (state == FS_WAIT) && !jump_i;
        // After a redirect into the upper halfword, the lower half of the
        // first word precedes the target and is skipped.
        push_cnt      = accept ? (misalign ? 2'd1 : 2'd2) : 2'd0;
        push_data     = misalign ? {{HW_W{1'b0}}, mem_rdata_i[WORD_W-1:HW_W]} : mem_rdata_i;
    end

    fetch_buffer u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (jump_i),
        .push_cnt  (push_cnt),
        .push_data (push_data),
        .pop_cnt   (pop_cnt),
        .slot0     (slot0),
        .slot1     (slot1),
        .count     (count)
    );

    // Request FSM plus fetch/issue pointers; a redirect overrides everything else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FS_IDLE;
            fetch_ptr  <= RESET_PC;
            instr_addr <= RESET_PC;
            misalign   <= 1'b0;
        end else if (jump_i) begin
            instr_addr <= jump_addr_i;
            fetch_ptr  <= {jump_addr_i[ADDR_W-1:2], 2'b00};
            misalign   <= jump_addr_i[1];
            unique case (state)
                // A response arriving with the jump is the stale one itself.
                FS_WAIT, FS_DROP: state <= mem_rvalid_i ? FS_IDLE : FS_DROP;
                default:          state <= FS_IDLE;
            endcase
        end else begin
            if (fire) begin
                instr_addr <= instr_addr + (rvc ? 32'd2 : 32'd4);
            end
            unique case (state)
                FS_IDLE: begin
                    if (mem_req_o) begin
                        fetch_ptr <= fetch_ptr + 32'd4;
                        state     <= FS_WAIT;
                    end
                end
                FS_WAIT: begin
                    if (mem_rvalid_i) begin
                        misalign <= 1'b0;
                        state    <= FS_IDLE;
                    end
                end
                FS_DROP: begin
                    if (mem_rvalid_i) begin
                        state <= FS_IDLE;
                    end
                end
                default: state <= FS_IDLE;
            endcase
        end
    end

    assign mem_addr_o   = fetch_ptr;
    assign instr_addr_o = instr_addr;

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have ports as follows, clock and reset first:
- clk  input  1  core clock.
- rst_n  input  1  reset, asynchronous, active-low.
- mem_req_o  output  1  instruction read request, one cycle per request.
- mem_addr_o  output  `RISCV_ADDR_WIDTH  word-aligned read address; [1:0]=0.
- mem_rvalid_i  input  1  read data valid.
- mem_rdata_i  input  `RISCV_WORD_WIDTH  read data, little-endian halfwords.
- jump_i  input  1  redirect request from execute.
- jump_addr_i  input  `RISCV_ADDR_WIDTH  redirect target; halfword-aligned.
- instr_o  output  `RISCV_WORD_WIDTH  raw instruction to the decoder; compressed instructions in [15:0], [31:16]=0.
- instr_addr_o  output  `RISCV_ADDR_WIDTH  address of instr_o.
- instr_valid_o  output  1  instr_o/instr_addr_o valid.
- instr_ready_i  input  1  decoder consumes instruction this cycle.

Function
REQ-003 SHALL hold a 3-halfword buffer with a count of 0..3 valid halfwords, oldest halfword at slot 0.
REQ-004 SHALL keep at most one outstanding memory request; pending flag set on mem_req_o, cleared on mem_rvalid_i.
REQ-005 SHALL assert mem_req_o, combinationally, when !pending && count<=1 && !jump_i.
REQ-006 SHALL drive mem_addr_o from the fetch pointer; the pointer advances by 4 on each issued request.
REQ-007 SHALL push both halfwords of mem_rdata_i on a non-dropped response, except the first response after a redirect with jump_addr_i[1]=1, which pushes only [31:16].
REQ-008 SHALL assert instr_valid_o when !jump_i && (count>=2 || (count==1 && slot0[1:0]!=2'b11)).
REQ-009 SHALL output instr_o = {slot1, slot0} for a 32-bit instruction and {16'h0, slot0} for a compressed one.
REQ-010 SHALL, on instr_valid_o && instr_ready_i, pop 2 halfwords (32-bit) or 1 (compressed), and advance instr_addr_o by 4 or 2.
REQ-011 SHALL handle push and pop in the same cycle as count_next = count - pop + push; no overflow is possible given REQ-005.
REQ-012 SHALL, on jump_i, in the same edge:
- flush the buffer (count=0);
- set instr_addr_o = jump_addr_i;
- set the fetch pointer = {jump_addr_i[31:2], 2'b00};
- record the misalign flag = jump_addr_i[1].
REQ-013 SHALL, if pending at jump_i, set a drop flag and discard the next response; the first new request is issued the cycle after that response.
REQ-014 SHALL give jump_i priority over a simultaneous response, pop or request; all three are discarded or suppressed.
REQ-015 SHALL, with no pending request at jump_i, issue the target request in cycle N+1 and present instr_valid_o no earlier than the cycle after mem_rvalid_i.
REQ-016 SHALL hold instr_o and instr_addr_o stable while instr_valid_o && !instr_ready_i.
REQ-017 SHALL wrap the address pointers modulo 2^32 without any flag.

Reset
REQ-018 SHALL, on rst_n low, asynchronously set count=0, pending=0, drop=0, misalign=0, instr_addr_o=RESET_PC, fetch pointer=RESET_PC; mem_req_o and instr_valid_o are therefore 0.
REQ-019 SHALL issue the first request to RESET_PC in the first cycle after rst_n deasserts.
REQ-020 SHALL, on reset mid-transaction, clear pending, and the bench SHALL not return the orphan response.

Structure
REQ-021 SHALL take `RISCV_WORD_WIDTH and `RISCV_ADDR_WIDTH from riscv_defines.v, and SHALL add a halfword-width constant there.
REQ-022 SHALL place the halfword queue (push 1/2, pop 1/2, flush, count) in one sub-module, fetch_buffer; the fetch FSM and address logic stay in instr_fetch.

Verification
REQ-023 Sequential 32-bit stream: memory returns 0x00000013 at 0x0 and 0x4, ready=1 -> instr_o=0x00000013 at addr 0x0 then 0x4, and never more than one request outstanding.
REQ-024 Compressed pair: word 0x00010001 at 0x0 -> two instructions 0x00000001, at addr 0x0 and 0x2.
REQ-025 Straddling instruction: words 0x00130001 at 0x0 and 0x00000000 at 0x4 -> 0x00000001 at addr 0x0, then 0x00000013 at addr 0x2, issued only after the second word arrives.
REQ-026 Misaligned jump: jump_i with target 0x102, word at 0x100 = 0x00010013 -> mem_addr_o=0x100; the first instruction has addr 0x102 and instr_o[15:0]=0x0001.
REQ-027 Jump with pending request: jump_i while the 0x8 request is pending -> the 0x8 data is dropped, the next mem_addr_o is the target, and no instruction at 0x8 is issued.
REQ-028 Backpressure and reset: ready=0 for 5 cycles -> instr_o stable and mem_req_o held low once count>=2; rst_n low mid-stream -> all outputs 0 the same cycle, then the request at RESET_PC after release.
